// File: rtl/rv_ctrl_pkg.sv
// Shared control-flow encodings and the resolved-entry record passed from
// branch resolution to PC select.
package rv_ctrl_pkg;

   localparam int RV_XLEN = 32;

   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_BR   = 2'b01;
   localparam logic [1:0] OP_JAL  = 2'b10;
   localparam logic [1:0] OP_JALR = 2'b11;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Address fields are sized by RV_XLEN, so the unit's XLEN must match it.
   typedef struct packed {
      logic               redirect;
      logic [RV_XLEN-1:0] target;
      logic [RV_XLEN-1:0] link;
      logic               illegal;
      logic               is_branch;
   } resolved_t;

endpackage

// File: rtl/br_cond_eval.sv
// Maps a branch funct3 and the ALU SUB flags (rs1 - rs2) to a taken/illegal
// decision. Purely combinational.
module br_cond_eval
   import rv_ctrl_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       negative,
   input  logic       overflow,
   input  logic       carry,
   output logic       taken,
   output logic       illegal
);

   // Carry is the no-borrow indication of rs1 + ~rs2 + 1, so it means rs1 >= rs2.
   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      case (funct3)
         F3_BEQ:  taken = zero;
         F3_BNE:  taken = ~zero;
         F3_BLT:  taken = negative ^ overflow;
         F3_BGE:  taken = ~(negative ^ overflow);
         F3_BLTU: taken = ~carry;
         F3_BGEU: taken = carry;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch/jump resolution with a 2-entry skid FIFO towards PC select
// and saturating taken/not-taken statistics counters.
module branch_resolve_unit
   import rv_ctrl_pkg::*;
#(
   parameter int XLEN  = RV_XLEN,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [2:0]       funct3,
   input  logic [XLEN-1:0]  pc,
   input  logic [XLEN-1:0]  imm,
   input  logic [XLEN-1:0]  alu_result,
   input  logic             zero,
   input  logic             negative,
   input  logic             overflow,
   input  logic             carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             redirect,
   output logic [XLEN-1:0]  target,
   output logic [XLEN-1:0]  link,
   output logic             illegal,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] not_taken_cnt
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   logic [1:0]       state_q, state_d;
   resolved_t        head_q, head_d;
   resolved_t        skid_q, skid_d;
   resolved_t        new_entry;
   logic [CNT_W-1:0] taken_q, taken_d;
   logic [CNT_W-1:0] not_taken_q, not_taken_d;
   logic             cond_taken, cond_illegal;
   logic             push, pop;
   logic             unused_alu_lsb;

   assign unused_alu_lsb = alu_result[0];

   br_cond_eval u_cond (
      .funct3   (funct3),
      .zero     (zero),
      .negative (negative),
      .overflow (overflow),
      .carry    (carry),
      .taken    (cond_taken),
      .illegal  (cond_illegal)
   );

   always_comb begin
      new_entry        = '0;
      new_entry.link   = pc + XLEN'(4);
      new_entry.target = pc + imm;
      case (op)
         OP_BR: begin
            new_entry.is_branch = 1'b1;
            new_entry.illegal   = cond_illegal;
            new_entry.redirect  = cond_taken & ~cond_illegal;
         end
         OP_JAL:  new_entry.redirect = 1'b1;
         OP_JALR: begin
            new_entry.redirect = 1'b1;
            new_entry.target   = {alu_result[XLEN-1:1], 1'b0};
         end
         default: ;
      endcase
   end

   // in_ready depends only on registered occupancy, never on out_ready.
   assign in_ready  = (state_q != ST_TWO);
   assign out_valid = (state_q != ST_EMPTY);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (push) begin
               head_d  = new_entry;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (push && pop) begin
               head_d = new_entry;
            end else if (push) begin
               skid_d  = new_entry;
               state_d = ST_TWO;
            end else if (pop) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (pop) begin
               head_d  = skid_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // Statistics are attributed when PC select consumes the entry, not on accept.
   always_comb begin
      taken_d     = taken_q;
      not_taken_d = not_taken_q;
      if (pop && head_q.redirect && (taken_q != {CNT_W{1'b1}})) begin
         taken_d = taken_q + CNT_W'(1);
      end
      if (pop && head_q.is_branch && !head_q.redirect && !head_q.illegal &&
          (not_taken_q != {CNT_W{1'b1}})) begin
         not_taken_d = not_taken_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         head_q      <= '0;
         skid_q      <= '0;
         taken_q     <= '0;
         not_taken_q <= '0;
      end else begin
         state_q     <= state_d;
         head_q      <= head_d;
         skid_q      <= skid_d;
         taken_q     <= taken_d;
         not_taken_q <= not_taken_d;
      end
   end

   assign redirect      = out_valid & head_q.redirect;
   assign illegal       = out_valid & head_q.illegal;
   assign target        = out_valid ? head_q.target : '0;
   assign link          = out_valid ? head_q.link : '0;
   assign taken_cnt     = taken_q;
   assign not_taken_cnt = not_taken_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: the driver pushes expected entries
// from a comparison-level model, a negedge monitor pops and compares.
module tb_branch_resolve_unit;

   localparam int XLEN    = 32;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = 3;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       op;
   logic [2:0]       funct3;
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  imm;
   logic [XLEN-1:0]  alu_result;
   logic             zero, negative, overflow, carry;
   logic             out_valid;
   logic             out_ready;
   logic             redirect;
   logic [XLEN-1:0]  target;
   logic [XLEN-1:0]  link;
   logic             illegal;
   logic [CNT_W-1:0] taken_cnt;
   logic [CNT_W-1:0] not_taken_cnt;

   typedef struct {
      logic        redirect;
      logic        illegal;
      logic [1:0]  op;
      logic [31:0] target;
      logic [31:0] link;
   } exp_t;

   exp_t sb[$];
   int   pend;
   int   m_taken;
   int   m_nt;
   int   compared;
   int   mismatched;
   bit   mon_en;

   branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .op            (op),
      .funct3        (funct3),
      .pc            (pc),
      .imm           (imm),
      .alu_result    (alu_result),
      .zero          (zero),
      .negative      (negative),
      .overflow      (overflow),
      .carry         (carry),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .redirect      (redirect),
      .target        (target),
      .link          (link),
      .illegal       (illegal),
      .taken_cnt     (taken_cnt),
      .not_taken_cnt (not_taken_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference decision made from the operand values themselves, not the flags.
   function automatic exp_t refModel(input logic [1:0] o, input logic [2:0] f3,
                                     input logic [31:0] p, input logic [31:0] im,
                                     input logic [31:0] rs1, input logic [31:0] rs2,
                                     input logic [31:0] alu);
      exp_t e;
      e.op       = o;
      e.link     = p + 32'd4;
      e.target   = p + im;
      e.redirect = 1'b0;
      e.illegal  = 1'b0;
      case (o)
         2'b01: begin
            case (f3)
               3'd0: e.redirect = (rs1 == rs2);
               3'd1: e.redirect = (rs1 != rs2);
               3'd4: e.redirect = ($signed(rs1) < $signed(rs2));
               3'd5: e.redirect = ($signed(rs1) >= $signed(rs2));
               3'd6: e.redirect = (rs1 < rs2);
               3'd7: e.redirect = (rs1 >= rs2);
               default: e.illegal = 1'b1;
            endcase
         end
         2'b10: e.redirect = 1'b1;
         2'b11: begin
            e.redirect = 1'b1;
            e.target   = alu & 32'hFFFF_FFFE;
         end
         default: ;
      endcase
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got,
                              input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // ALU flags as the core ALU produces them for SUB rs1-rs2.
   task automatic applyStimulus(input logic v, input logic [1:0] o, input logic [2:0] f3,
                                input logic [31:0] p, input logic [31:0] im,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] alu, input logic rdy);
      logic [32:0] wide;
      @(posedge clk);
      #1;
      wide       = {1'b0, rs1} + {1'b0, ~rs2} + 33'd1;
      in_valid   = v;
      op         = o;
      funct3     = f3;
      pc         = p;
      imm        = im;
      alu_result = alu;
      carry      = wide[32];
      zero       = (wide[31:0] == 32'd0);
      negative   = wide[31];
      overflow   = (rs1[31] != rs2[31]) && (wide[31] != rs1[31]);
      out_ready  = rdy;
      pend       = 0;
      if (v && (sb.size() < 2)) begin
         sb.push_back(refModel(o, f3, p, im, rs1, rs2, alu));
         pend = 1;
      end
   endtask

   task automatic applyReset();
      @(posedge clk);
      #3;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      sb.delete();
      pend    = 0;
      m_taken = 0;
      m_nt    = 0;
      #1;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_redirect", 32'(redirect), 32'd0);
      checkOutput("rst_target", target, 32'd0);
      checkOutput("rst_link", link, 32'd0);
      checkOutput("rst_illegal", 32'(illegal), 32'd0);
      checkOutput("rst_taken_cnt", 32'(taken_cnt), 32'd0);
      checkOutput("rst_not_taken_cnt", 32'(not_taken_cnt), 32'd0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      int occ;
      if (mon_en) begin
         occ = sb.size() - pend;
         checkOutput("in_ready", 32'(in_ready), 32'(occ < 2));
         checkOutput("out_valid", 32'(out_valid), 32'(occ > 0));
         checkOutput("taken_cnt", 32'(taken_cnt), 32'(m_taken));
         checkOutput("not_taken_cnt", 32'(not_taken_cnt), 32'(m_nt));
         if (occ > 0) begin
            checkOutput("redirect", 32'(redirect), 32'(sb[0].redirect));
            checkOutput("illegal", 32'(illegal), 32'(sb[0].illegal));
            checkOutput("link", link, sb[0].link);
            if (sb[0].op != 2'b00) begin
               checkOutput("target", target, sb[0].target);
            end
            if (out_ready && rst_n) begin
               if (sb[0].redirect) begin
                  m_taken = (m_taken < CNT_MAX) ? m_taken + 1 : m_taken;
               end else if (sb[0].op == 2'b01 && !sb[0].illegal) begin
                  m_nt = (m_nt < CNT_MAX) ? m_nt + 1 : m_nt;
               end
               void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      compared   = 0;
      mismatched = 0;
      pend       = 0;
      m_taken    = 0;
      m_nt       = 0;
      mon_en     = 1'b0;
      rst_n      = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      op         = 2'b00;
      funct3     = 3'b000;
      pc         = '0;
      imm        = '0;
      alu_result = '0;
      zero       = 1'b0;
      negative   = 1'b0;
      overflow   = 1'b0;
      carry      = 1'b0;
      #1 rst_n = 1'b0;
      mon_en = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      checkOutput("init_out_valid", 32'(out_valid), 32'd0);
      checkOutput("init_taken_cnt", 32'(taken_cnt), 32'd0);
      rst_n = 1'b1;

      $display("[TB] directed branches and jumps");
      applyStimulus(1, 2'b01, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5, 32'd0, 1);
      applyStimulus(1, 2'b01, 3'd4, 32'h200, 32'h40, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1);
      applyStimulus(1, 2'b01, 3'd6, 32'h300, 32'h10, 32'd1, 32'd2, 32'd0, 1);
      applyStimulus(1, 2'b11, 3'd0, 32'h400, 32'd0, 32'd0, 32'd0, 32'h2003, 1);
      applyStimulus(1, 2'b10, 3'd0, 32'hFFFF_FFFC, 32'd8, 32'd0, 32'd0, 32'd0, 1);

      $display("[TB] stall with three offers, then drain");
      applyStimulus(1, 2'b01, 3'd1, 32'h500, 32'h8, 32'd1, 32'd2, 32'd0, 0);
      applyStimulus(1, 2'b10, 3'd0, 32'h600, 32'h100, 32'd0, 32'd0, 32'd0, 0);
      applyStimulus(1, 2'b01, 3'd7, 32'h700, 32'h4, 32'd9, 32'd3, 32'd0, 0);
      repeat (3) applyStimulus(0, 2'b00, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0);
      repeat (4) applyStimulus(0, 2'b00, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1);

      $display("[TB] illegal funct3, op none, taken saturation");
      applyStimulus(1, 2'b01, 3'd2, 32'h800, 32'h10, 32'd4, 32'd4, 32'd0, 1);
      applyStimulus(1, 2'b01, 3'd3, 32'h900, 32'h10, 32'd4, 32'd5, 32'd0, 1);
      applyStimulus(1, 2'b00, 3'd0, 32'hA00, 32'h10, 32'd0, 32'd0, 32'd0, 1);
      repeat (5) applyStimulus(1, 2'b10, 3'd0, 32'hB00, 32'h20, 32'd0, 32'd0, 32'd0, 1);
      repeat (2) applyStimulus(0, 2'b00, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1);

      $display("[TB] reset during stall with two entries");
      applyStimulus(1, 2'b10, 3'd0, 32'hC00, 32'h4, 32'd0, 32'd0, 32'd0, 0);
      applyStimulus(1, 2'b01, 3'd0, 32'hD00, 32'h4, 32'd7, 32'd7, 32'd0, 0);
      applyStimulus(0, 2'b00, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0);
      applyReset();

      $display("[TB] randomized traffic");
      for (int round = 0; round < 4; round++) begin
         for (int n = 0; n < 400; n++) begin
            logic [31:0] r1, r2;
            r1 = $urandom;
            r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
            applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                          3'($urandom_range(0, 7)), $urandom, $urandom, r1, r2,
                          $urandom, $urandom_range(0, 3) != 0);
         end
         if (round < 3) begin
            applyReset();
         end
      end

      for (int n = 0; n < 10 && sb.size() > 0; n++) begin
         applyStimulus(0, 2'b00, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1);
      end
      @(posedge clk);
      checkOutput("drain_remaining", 32'(sb.size()), 32'd0);
      @(negedge clk);
      mon_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
